pixel_fetch: RTL and testbench

Downstream consumer of the pixel address FIFO. Pops 20-bit entries ({valid, 19-bit pixel address}), issues SRAM reads for valid entries and substitutes a blank colour for invalid (out-of-picture) entries. Results land in a small show-ahead output buffer that feeds the display pixel request interface at up to one pixel per clock. A credit count bounds outstanding reads so the output buffer can never overflow.

---
 rtl/pixel_fetch.sv | 69 ++++++
 tb/tb_pixel_fetch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fetch.sv
// pixel_fetch: pops pixel addresses, reads SRAM (or substitutes blank), and buffers pixels show-ahead.
// Credits (occupancy + in_flight) bound pops so the output buffer never overflows.
module pixel_fetch #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 16,
   parameter int SRAM_LATENCY = 2,
   parameter int OUT_DEPTH = 8,
   parameter logic [DATA_W-1:0] BLANK_PIXEL = '0
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [ADDR_W:0]   iADDRESS,
   input  logic              iREADY_N,
   output logic              oREAD,
   output logic [ADDR_W-1:0] oSRAM_ADDR,
   output logic              oSRAM_RD,
   input  logic [DATA_W-1:0] iSRAM_DATA,
   input  logic              iPIXEL_REQ,
   output logic [DATA_W-1:0] oPIXEL,
   output logic              oPIXEL_VALID,
   output logic              oUNDERFLOW
);
   localparam int PW = $clog2(OUT_DEPTH);
   localparam int CW = PW + 1;
   localparam int L = SRAM_LATENCY;
   logic [DATA_W-1:0] mem [OUT_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] occ, in_flight;
   logic stage_a;
   logic [L:0] live, fetch;
   logic wr, pop;
   logic [DATA_W-1:0] wr_data;
   always_comb begin
      oREAD = !RESET && !iREADY_N && ({1'b0, occ} + {1'b0, in_flight} < (CW+1)'(OUT_DEPTH));
      oPIXEL_VALID = occ != '0;
      pop = iPIXEL_REQ && oPIXEL_VALID;
      oUNDERFLOW = !RESET && iPIXEL_REQ && !oPIXEL_VALID;
      oPIXEL = oPIXEL_VALID ? mem[rd_ptr] : BLANK_PIXEL;
      wr = live[L];
      wr_data = fetch[L] ? iSRAM_DATA : BLANK_PIXEL;
   end
   // Tag bit 0 lines up with oSRAM_RD; bit L lines up with the returning SRAM data.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         stage_a <= 1'b0;
         oSRAM_RD <= 1'b0;
         oSRAM_ADDR <= '0;
         live <= '0;
         fetch <= '0;
         in_flight <= '0;
         occ <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         stage_a <= oREAD;
         oSRAM_RD <= stage_a && iADDRESS[ADDR_W];
         if (stage_a && iADDRESS[ADDR_W]) oSRAM_ADDR <= iADDRESS[ADDR_W-1:0];
         live <= {live[L-1:0], stage_a};
         fetch <= {fetch[L-1:0], stage_a && iADDRESS[ADDR_W]};
         in_flight <= in_flight + CW'(oREAD) - CW'(wr);
         occ <= occ + CW'(wr) - CW'(pop);
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end
   always_ff @(posedge CLK) begin
      if (wr) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: tb/tb_pixel_fetch.sv
// tb_pixel_fetch: table vectors, directed corner sequences and random traffic against a
// pop-time/latency model of the pixel fetch path.
module tb_pixel_fetch;
   localparam int L = 2;
   localparam int D = 8;
   localparam logic [15:0] BL = 16'h0000;

   logic CLK = 1'b0;
   logic RESET;
   logic [19:0] iADDRESS;
   logic iREADY_N;
   logic oREAD;
   logic [18:0] oSRAM_ADDR;
   logic oSRAM_RD;
   logic [15:0] iSRAM_DATA;
   logic iPIXEL_REQ;
   logic [15:0] oPIXEL;
   logic oPIXEL_VALID;
   logic oUNDERFLOW;

   pixel_fetch #(.ADDR_W(19), .DATA_W(16), .SRAM_LATENCY(L), .OUT_DEPTH(D), .BLANK_PIXEL(BL)) dut (
      .CLK(CLK), .RESET(RESET), .iADDRESS(iADDRESS), .iREADY_N(iREADY_N), .oREAD(oREAD),
      .oSRAM_ADDR(oSRAM_ADDR), .oSRAM_RD(oSRAM_RD), .iSRAM_DATA(iSRAM_DATA),
      .iPIXEL_REQ(iPIXEL_REQ), .oPIXEL(oPIXEL), .oPIXEL_VALID(oPIXEL_VALID), .oUNDERFLOW(oUNDERFLOW)
   );

   always #5 CLK = ~CLK;

   typedef struct {int rdy; logic [15:0] pix;} pend_t;
   typedef struct {int c; logic [18:0] a;} iss_t;
   typedef struct {logic v; logic [18:0] a; logic [15:0] pix;} vec_t;

   pend_t pend[$];
   iss_t iss[$];
   logic [19:0] fifo[$];
   logic [15:0] got[$];
   logic [15:0] sp [1:L];
   logic [18:0] exp_addr = '0;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   logic s_read, s_rd, s_valid, s_uf;
   logic [18:0] s_addr;
   int s_cyc;
   vec_t tbl[8];

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
      end
   endtask

   task automatic push(input logic v, input logic [18:0] a);
      fifo.push_back({v, a});
      iREADY_N = 1'b0;
   endtask

   // One clock: check outputs mid-cycle against the model, then advance model and environment.
   task automatic step();
      logic [19:0] f, nxt;
      logic [15:0] pix, e_pix;
      logic e_valid, e_read, e_rd, e_uf;
      @(negedge CLK);
      while (iss.size() > 0 && iss[0].c + 2 < cyc) void'(iss.pop_front());
      e_rd = iss.size() > 0 && iss[0].c + 2 == cyc;
      if (e_rd) exp_addr = iss[0].a;
      e_valid = pend.size() > 0 && pend[0].rdy <= cyc;
      e_pix = e_valid ? pend[0].pix : BL;
      e_read = !RESET && fifo.size() > 0 && pend.size() < D;
      e_uf = !RESET && iPIXEL_REQ && !e_valid;
      chk("oREAD", 32'(oREAD), 32'(e_read));
      chk("oSRAM_RD", 32'(oSRAM_RD), 32'(e_rd));
      chk("oSRAM_ADDR", 32'(oSRAM_ADDR), 32'(exp_addr));
      chk("oPIXEL_VALID", 32'(oPIXEL_VALID), 32'(e_valid));
      chk("oPIXEL", 32'(oPIXEL), 32'(e_pix));
      chk("oUNDERFLOW", 32'(oUNDERFLOW), 32'(e_uf));
      s_read = oREAD; s_rd = oSRAM_RD; s_addr = oSRAM_ADDR;
      s_valid = oPIXEL_VALID; s_uf = oUNDERFLOW; s_cyc = cyc;
      nxt = 20'($urandom);
      if (iPIXEL_REQ && oPIXEL_VALID && !RESET) got.push_back(oPIXEL);
      if (RESET) begin
         pend.delete();
         iss.delete();
         exp_addr = '0;
      end else begin
         if (oREAD && fifo.size() > 0) begin
            f = fifo.pop_front();
            nxt = f;
            pix = f[19] ? 16'(f[18:0] + 19'h100) : BL;
            pend.push_back('{cyc + 3 + L, pix});
            if (f[19]) iss.push_back('{cyc, f[18:0]});
         end
         if (iPIXEL_REQ && e_valid) void'(pend.pop_front());
      end
      @(posedge CLK);
      for (int k = L; k > 1; k--) sp[k] = sp[k-1];
      sp[1] = s_rd ? 16'(s_addr + 19'h100) : 16'hDEAD;
      #1;
      cyc++;
      iADDRESS = nxt;
      iSRAM_DATA = sp[L];
      iREADY_N = fifo.size() == 0;
   endtask

   initial begin
      int r0, rd0, v0, n, nv;
      logic [18:0] a0;
      RESET = 1'b1; iADDRESS = '0; iREADY_N = 1'b1; iSRAM_DATA = '0; iPIXEL_REQ = 1'b0;
      for (int k = 1; k <= L; k++) sp[k] = '0;
      tbl[0] = '{1'b1, 19'h00010, 16'h0110};
      tbl[1] = '{1'b1, 19'h00011, 16'h0111};
      tbl[2] = '{1'b1, 19'h00012, 16'h0112};
      tbl[3] = '{1'b0, 19'h7FFFF, 16'h0000};
      tbl[4] = '{1'b1, 19'h00005, 16'h0105};
      tbl[5] = '{1'b1, 19'h7FFFF, 16'h00FF};
      tbl[6] = '{1'b1, 19'h00000, 16'h0100};
      tbl[7] = '{1'b0, 19'h12345, 16'h0000};
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
      step();
      chk("reset_read", 32'(s_read), 32'd0);
      chk("reset_valid", 32'(s_valid), 32'd0);
      chk("reset_addr", 32'(s_addr), 32'd0);

      // basic fetch order and latency
      for (int i = 0; i < 3; i++) push(tbl[i].v, tbl[i].a);
      iPIXEL_REQ = 1'b1;
      r0 = -1; rd0 = -1; v0 = -1;
      repeat (15) begin
         step();
         if (s_read && r0 < 0) r0 = s_cyc;
         if (s_rd && rd0 < 0) rd0 = s_cyc;
         if (s_valid && v0 < 0) v0 = s_cyc;
      end
      chk("rd_latency", 32'(rd0 - r0), 32'd2);
      chk("pix_latency", 32'(v0 - r0), 32'd5);

      // invalid substitution and boundary addresses
      nv = 0;
      for (int i = 3; i < 8; i++) begin
         push(tbl[i].v, tbl[i].a);
         nv += int'(tbl[i].v);
      end
      n = 0; a0 = '1;
      repeat (20) begin
         step();
         if (s_rd) begin
            if (n == 0) a0 = s_addr;
            n++;
         end
      end
      chk("rd_count", 32'(n), 32'(nv));
      chk("first_rd_addr", 32'(a0), 32'h5);
      chk("tbl_count", 32'(got.size()), 32'd8);
      for (int i = 0; i < 8; i++)
         chk("tbl_pixel", i < got.size() ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(tbl[i].pix));

      // underflow
      iPIXEL_REQ = 1'b0;
      repeat (3) step();
      n = 0; nv = 0;
      iPIXEL_REQ = 1'b1;
      repeat (2) begin step(); n += int'(s_uf); nv += int'(s_valid); end
      iPIXEL_REQ = 1'b0;
      repeat (2) begin step(); n += int'(s_uf); nv += int'(s_valid); end
      chk("uf_count", 32'(n), 32'd2);
      chk("uf_valid", 32'(nv), 32'd0);
      got.delete();
      push(1'b1, 19'h00042);
      iPIXEL_REQ = 1'b1;
      repeat (12) step();
      chk("uf_after_count", 32'(got.size()), 32'd1);
      chk("uf_after_pix", got.size() > 0 ? 32'(got[0]) : 32'hFFFF_FFFF, 32'h0142);

      // back-pressure: credits stop popping at exactly D entries
      iPIXEL_REQ = 1'b0;
      got.delete();
      for (int i = 0; i < 120; i++) push(1'b1, 19'(32'h100 + i));
      n = 0;
      repeat (30) begin step(); n += int'(s_read); end
      chk("bp_pops", 32'(n), 32'(D));
      iPIXEL_REQ = 1'b1;
      n = 0; nv = 0;
      repeat (100) begin step(); n += int'(s_valid); nv += int'(s_uf); end
      chk("bp_delivered", 32'(n), 32'd100);
      chk("bp_underflow", 32'(nv), 32'd0);
      n = 0;
      for (int i = 0; i < 100 && i < got.size(); i++) if (got[i] != 16'(32'h200 + i)) n++;
      chk("bp_order_errs", 32'(n), 32'd0);
      repeat (30) step();

      // full buffer with simultaneous push and pop: sequence scoreboard
      iPIXEL_REQ = 1'b0;
      got.delete();
      for (int i = 0; i < 40; i++) push(1'b1, 19'(32'h1000 + i));
      repeat (15) step();
      iPIXEL_REQ = 1'b1;
      repeat (45) step();
      chk("full_count", 32'(got.size()), 32'd40);
      n = 0;
      for (int i = 0; i < got.size(); i++) if (got[i] != 16'(32'h1100 + i)) n++;
      chk("full_seq_errs", 32'(n), 32'd0);

      // reset with 3 reads in flight and 4 pixels buffered
      iPIXEL_REQ = 1'b0;
      repeat (3) step();
      for (int i = 0; i < 7; i++) push(1'b1, 19'(32'h2000 + i));
      repeat (8) step();
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      step();
      chk("rst_read", 32'(s_read), 32'd0);
      chk("rst_rd", 32'(s_rd), 32'd0);
      chk("rst_addr", 32'(s_addr), 32'd0);
      chk("rst_valid", 32'(s_valid), 32'd0);
      chk("rst_uf", 32'(s_uf), 32'd0);
      nv = 0;
      repeat (10) begin step(); nv += int'(s_valid); end
      chk("rst_no_capture", 32'(nv), 32'd0);
      got.delete();
      push(1'b1, 19'h00077);
      iPIXEL_REQ = 1'b1;
      r0 = -1; v0 = -1;
      repeat (12) begin
         step();
         if (s_read && r0 < 0) r0 = s_cyc;
         if (s_valid && v0 < 0) v0 = s_cyc;
      end
      chk("rst_latency", 32'(v0 - r0), 32'd5);
      chk("rst_pix", got.size() > 0 ? 32'(got[0]) : 32'hFFFF_FFFF, 32'h0177);

      // random traffic with occasional resets
      repeat (2500) begin
         if ($urandom_range(0, 2) == 0 && fifo.size() < 20)
            push(1'($urandom_range(0, 3) != 0), 19'($urandom));
         iPIXEL_REQ = $urandom_range(0, 2) != 0;
         RESET = $urandom_range(0, 199) == 0;
         step();
      end
      RESET = 1'b0;
      iPIXEL_REQ = 1'b1;
      repeat (60) step();
      chk("drain_empty", 32'(s_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
